// File: rtl/sa_skew_feeder_if.sv
// Slice stream from the operand buffers into the skew feeder:
// one A column and one B row per handshake.
interface sa_skew_feeder_if #(
   parameter int D_W  = 8,
   parameter int SA_R = 16,
   parameter int SA_C = 16
);
   logic                     I_VLD;
   logic                     O_RDY;
   logic [SA_R-1:0][D_W-1:0] I_A_COL;
   logic [SA_C-1:0][D_W-1:0] I_B_ROW;

   modport master (output I_VLD, output I_A_COL, output I_B_ROW, input O_RDY);
   modport slave  (input I_VLD, input I_A_COL, input I_B_ROW, output O_RDY);
endinterface

// File: rtl/sa_skew_feeder.sv
// Systolic-array edge feeder: turns one k-slice per cycle into diagonally
// skewed X/W lane streams and brackets each job with start/end flags.
module sa_skew_feeder #(
   parameter int D_W   = 8,
   parameter int SA_R  = 16,
   parameter int SA_C  = 16,
   parameter int K_LEN = 16
) (
   input  logic                     I_CLK,
   input  logic                     I_RST,
   input  logic                     I_START,
   sa_skew_feeder_if.slave          s_if,
   output logic [SA_R-1:0][D_W-1:0] O_X,
   output logic [SA_C-1:0][D_W-1:0] O_W,
   output logic                     O_START_FLAG,
   output logic                     O_END_FLAG,
   output logic                     O_BUSY
);
   localparam int KW = $clog2(K_LEN + 1);
   localparam int DW = $clog2(SA_R + SA_C);
   localparam logic [KW-1:0] K_LAST = KW'(K_LEN - 1);
   localparam logic [DW-1:0] D_LAST = DW'(SA_R + SA_C - 2);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_FEED  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_END   = 3'd4;

   logic [2:0]               state_q, state_d;
   logic [KW-1:0]            k_q, k_d;
   logic [DW-1:0]            drain_q, drain_d;
   logic                     take;
   logic [SA_R-1:0][D_W-1:0] x_in;
   logic [SA_C-1:0][D_W-1:0] w_in;

   assign take         = (state_q == ST_FEED) && s_if.I_VLD;
   assign s_if.O_RDY   = (state_q == ST_FEED);
   assign O_START_FLAG = (state_q == ST_START);
   assign O_END_FLAG   = (state_q == ST_END);
   assign O_BUSY       = (state_q != ST_IDLE);

   // Missing slices become zero bubbles so every lane stays diagonally aligned.
   assign x_in = take ? s_if.I_A_COL : '0;
   assign w_in = take ? s_if.I_B_ROW : '0;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE: begin
            if (I_START) state_d = ST_START;
         end
         ST_START: begin
            state_d = ST_FEED;
            k_d     = '0;
         end
         ST_FEED: begin
            if (take) begin
               k_d = k_q + 1'b1;
               if (k_q == K_LAST) begin
                  state_d = ST_DRAIN;
                  drain_d = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == D_LAST) state_d = ST_END;
            else                   drain_d = drain_q + 1'b1;
         end
         ST_END: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         drain_q <= drain_d;
      end
   end

   // Lane i holds stage 0 plus i extra registers; the last one drives the edge.
   for (genvar i = 0; i < SA_R; i++) begin : g_x
      logic [i:0][D_W-1:0] pipe_q, pipe_d;

      always_comb begin
         pipe_d    = '0;
         pipe_d[0] = x_in[i];
         for (int unsigned j = 1; j <= unsigned'(i); j++) pipe_d[j] = pipe_q[j-1];
      end

      always_ff @(posedge I_CLK) begin
         if (I_RST) pipe_q <= '0;
         else       pipe_q <= pipe_d;
      end

      assign O_X[i] = pipe_q[i];
   end

   for (genvar i = 0; i < SA_C; i++) begin : g_w
      logic [i:0][D_W-1:0] pipe_q, pipe_d;

      always_comb begin
         pipe_d    = '0;
         pipe_d[0] = w_in[i];
         for (int unsigned j = 1; j <= unsigned'(i); j++) pipe_d[j] = pipe_q[j-1];
      end

      always_ff @(posedge I_CLK) begin
         if (I_RST) pipe_q <= '0;
         else       pipe_q <= pipe_d;
      end

      assign O_W[i] = pipe_q[i];
   end
endmodule

// File: tb/tb_sa_skew_feeder.sv
// Runs 2x2/K=3, 1x1/K=1 and 16x16/K=16 feeders side by side from shared
// control and random data, checked against a per-job timeline model.
module tb_sa_skew_feeder;
   localparam int NW  = 1024;
   localparam int BIG = 32'h3fff_ffff;

   logic clk = 1'b0;
   logic rst, start, vld;
   logic [15:0][7:0] a_all, b_all;

   always #5 clk = ~clk;

   sa_skew_feeder_if #(.D_W(8), .SA_R(2),  .SA_C(2))  if0 ();
   sa_skew_feeder_if #(.D_W(8), .SA_R(1),  .SA_C(1))  if1 ();
   sa_skew_feeder_if #(.D_W(8), .SA_R(16), .SA_C(16)) if2 ();

   assign if0.I_VLD   = vld;
   assign if0.I_A_COL = a_all[1:0];
   assign if0.I_B_ROW = b_all[1:0];
   assign if1.I_VLD   = vld;
   assign if1.I_A_COL = a_all[0:0];
   assign if1.I_B_ROW = b_all[0:0];
   assign if2.I_VLD   = vld;
   assign if2.I_A_COL = a_all;
   assign if2.I_B_ROW = b_all;

   logic [1:0][7:0]  x0, w0;
   logic [0:0][7:0]  x1, w1;
   logic [15:0][7:0] x2, w2;
   logic [2:0]       sf, ef, by, rd;
   logic [15:0][7:0] xo [3];
   logic [15:0][7:0] wo [3];

   assign rd    = {if2.O_RDY, if1.O_RDY, if0.O_RDY};
   assign xo[0] = {112'd0, x0};
   assign wo[0] = {112'd0, w0};
   assign xo[1] = {120'd0, x1};
   assign wo[1] = {120'd0, w1};
   assign xo[2] = x2;
   assign wo[2] = w2;

   sa_skew_feeder #(.D_W(8), .SA_R(2), .SA_C(2), .K_LEN(3)) dut0 (
      .I_CLK(clk), .I_RST(rst), .I_START(start), .s_if(if0),
      .O_X(x0), .O_W(w0), .O_START_FLAG(sf[0]), .O_END_FLAG(ef[0]), .O_BUSY(by[0]));
   sa_skew_feeder #(.D_W(8), .SA_R(1), .SA_C(1), .K_LEN(1)) dut1 (
      .I_CLK(clk), .I_RST(rst), .I_START(start), .s_if(if1),
      .O_X(x1), .O_W(w1), .O_START_FLAG(sf[1]), .O_END_FLAG(ef[1]), .O_BUSY(by[1]));
   sa_skew_feeder #(.D_W(8), .SA_R(16), .SA_C(16), .K_LEN(16)) dut2 (
      .I_CLK(clk), .I_RST(rst), .I_START(start), .s_if(if2),
      .O_X(x2), .O_W(w2), .O_START_FLAG(sf[2]), .O_END_FLAG(ef[2]), .O_BUSY(by[2]));

   int pr [3] = '{2, 1, 16};
   int pc [3] = '{2, 1, 16};
   int pk [3] = '{3, 1, 16};

   // Slice entering stage 0 in each cycle (zero for bubbles / idle cycles).
   logic [15:0][7:0] hx [3][NW];
   logic [15:0][7:0] hw [3][NW];
   bit m_act [3];
   int m_sw [3];
   int m_acc [3];
   int m_ew [3];
   int rw, cyc, total, bad;

   function automatic bit f_rdy(input int d);
      return m_act[d] && (cyc > m_sw[d]) && (m_acc[d] < pk[d]);
   endfunction

   task automatic cmp(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d cyc=%0d got=%h want=%h", tag, d, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [15:0][7:0] ex_x, ex_w;
      for (int d = 0; d < 3; d++) begin
         ex_x = '0;
         ex_w = '0;
         for (int i = 0; i < pr[d]; i++)
            if (cyc - i >= rw) ex_x[i] = hx[d][cyc-i][i];
         for (int j = 0; j < pc[d]; j++)
            if (cyc - j >= rw) ex_w[j] = hw[d][cyc-j][j];
         cmp("o_x", d, xo[d], ex_x);
         cmp("o_w", d, wo[d], ex_w);
         cmp("start_flag", d, sf[d], m_act[d] && cyc == m_sw[d]);
         cmp("end_flag", d, ef[d], m_act[d] && cyc == m_ew[d]);
         cmp("busy", d, by[d], m_act[d]);
         cmp("rdy", d, rd[d], f_rdy(d));
      end
   endtask

   // Drive inputs for the next edge, advance the model, then check that cycle.
   task automatic step(input bit t_rst, input bit t_start, input bit t_vld);
      for (int l = 0; l < 16; l++) begin
         a_all[l] = 8'($urandom);
         b_all[l] = 8'($urandom);
      end
      rst   = t_rst;
      start = t_start;
      vld   = t_vld;
      for (int d = 0; d < 3; d++) begin
         hx[d][cyc+1] = '0;
         hw[d][cyc+1] = '0;
         if (t_rst) begin
            m_act[d] = 1'b0;
            m_ew[d]  = BIG;
         end else if (!m_act[d]) begin
            if (t_start) begin
               m_act[d] = 1'b1;
               m_sw[d]  = cyc + 1;
               m_acc[d] = 0;
               m_ew[d]  = BIG;
            end
         end else begin
            if (f_rdy(d) && t_vld) begin
               hx[d][cyc+1] = a_all;
               hw[d][cyc+1] = b_all;
               m_acc[d]++;
               if (m_acc[d] == pk[d]) m_ew[d] = cyc + 1 + pr[d] + pc[d] - 1;
            end
            if (cyc == m_ew[d]) m_act[d] = 1'b0;
         end
      end
      if (t_rst) rw = cyc + 1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_all();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      rw    = 0;
      for (int d = 0; d < 3; d++) begin
         m_act[d] = 1'b0;
         m_sw[d]  = 0;
         m_acc[d] = 0;
         m_ew[d]  = BIG;
      end
      rst   = 1'b1;
      start = 1'b0;
      vld   = 1'b0;
      a_all = '0;
      b_all = '0;

      step(1, 0, 0);
      step(1, 0, 0);
      step(0, 0, 0);

      // continuous job, with I_START repeated during FEED and DRAIN
      step(0, 1, 0);
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 1, 1);
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 1, 1);
      repeat (55) step(0, 0, 1);

      // two bubbles after the first slice
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      step(0, 0, 0);
      repeat (55) step(0, 0, 1);

      // reset after the first slice, then a fresh job
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      step(1, 0, 1);
      step(0, 0, 0);
      step(0, 1, 0);
      repeat (55) step(0, 0, 1);

      repeat (600)
         step($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
